updown_counter_param: RTL and testbench



---
 rtl/updown_counter_param_if.sv | 30 +++
 rtl/updown_counter_param.sv | 135 +++++++++++++
 tb/tb_updown_counter_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param.
//   master : drives EN, LOAD, X, direction, value, mode, limit, ovf_clr;
//            observes out, tc, ovf
//   slave  : the counter side (inverse directions)
interface updown_counter_param_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STEP_WIDTH = 3
);
  logic                  EN;
  logic                  LOAD;
  logic [WIDTH-1:0]      X;
  logic                  direction;
  logic [STEP_WIDTH-1:0] value;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      limit;
  logic                  ovf_clr;
  logic [WIDTH-1:0]      out;
  logic                  tc;
  logic                  ovf;

  modport master (
    output EN, LOAD, X, direction, value, mode, limit, ovf_clr,
    input  out, tc, ovf
  );

  modport slave (
    input  EN, LOAD, X, direction, value, mode, limit, ovf_clr,
    output out, tc, ovf
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised load/clear up/down counter with programmable step and
// wrap / saturate / modulo-limit overflow handling.
//   CLK   : rising-edge clock
//   CLEAR : asynchronous active-low reset (out, tc, ovf -> 0)
//   bus   : slave side of updown_counter_param_if
//           EN, LOAD, X, direction, value, mode, limit, ovf_clr in;
//           out (count), tc (one-cycle event pulse), ovf (sticky event flag) out
// Requires WIDTH >= 2 and STEP_WIDTH <= WIDTH.
module updown_counter_param #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STEP_WIDTH = 3
) (
  input  logic                   CLK,
  input  logic                   CLEAR,
  updown_counter_param_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_MOD  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] out_q;
  logic             tc_q;
  logic             ovf_q;

  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   lim;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mod_up;
  logic [WIDTH:0]   mod_dn;
  logic [WIDTH-1:0] cnt_next;
  logic             evt;
  logic [WIDTH-1:0] load_val;
  mode_e            mode;

  assign mode   = mode_e'(bus.mode);
  assign cur    = {1'b0, out_q};
  assign step   = {{(WIDTH+1-STEP_WIDTH){1'b0}}, bus.value};
  assign lim    = {1'b0, bus.limit};
  assign sum    = cur + step;
  assign diff   = cur - step;
  // Modulo wrap in WIDTH+1 bits; both results fit in WIDTH bits whenever
  // they are selected (out <= limit and value <= limit at that point).
  assign mod_up = sum - lim - (WIDTH+1)'(1);
  assign mod_dn = cur + lim + (WIDTH+1)'(1) - step;

  assign load_val = (mode == MODE_MOD && bus.X > bus.limit) ? bus.limit : bus.X;

  always_comb begin
    cnt_next = out_q;
    evt      = 1'b0;
    if (step != '0) begin
      case (mode)
        MODE_SAT: begin
          if (bus.direction) begin
            if (sum[WIDTH]) begin
              cnt_next = '1;
              evt      = 1'b1;
            end else begin
              cnt_next = sum[WIDTH-1:0];
            end
          end else begin
            if (diff[WIDTH]) begin
              cnt_next = '0;
              evt      = 1'b1;
            end else begin
              cnt_next = diff[WIDTH-1:0];
            end
          end
        end
        MODE_MOD: begin
          // A step larger than the range is a misconfiguration: hold and flag.
          if (step > lim) begin
            evt = 1'b1;
          end else if (cur > lim) begin
            cnt_next = bus.direction ? '0 : bus.limit;
            evt      = 1'b1;
          end else if (bus.direction) begin
            if (sum > lim) begin
              cnt_next = mod_up[WIDTH-1:0];
              evt      = 1'b1;
            end else begin
              cnt_next = sum[WIDTH-1:0];
            end
          end else begin
            if (step > cur) begin
              cnt_next = mod_dn[WIDTH-1:0];
              evt      = 1'b1;
            end else begin
              cnt_next = diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          if (bus.direction) begin
            cnt_next = sum[WIDTH-1:0];
            evt      = sum[WIDTH];
          end else begin
            cnt_next = diff[WIDTH-1:0];
            evt      = diff[WIDTH];
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.LOAD) begin
      out_q <= load_val;
      tc_q  <= 1'b0;
      ovf_q <= ovf_q & ~bus.ovf_clr;
    end else if (bus.EN) begin
      out_q <= cnt_next;
      tc_q  <= evt;
      ovf_q <= evt | (ovf_q & ~bus.ovf_clr);
    end else begin
      tc_q  <= 1'b0;
      ovf_q <= ovf_q & ~bus.ovf_clr;
    end
  end

  assign bus.out = out_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench for updown_counter_param (WIDTH=16, STEP_WIDTH=3).
module tb_updown_counter_param;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 3;

  logic CLK;
  logic CLEAR;
  int unsigned n_checks;
  int unsigned n_errors;

  updown_counter_param_if #(.WIDTH(W), .STEP_WIDTH(SW)) ifc ();

  updown_counter_param #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .bus   (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int unsigned o, input int unsigned t,
                           input int unsigned v);
    check({tag, ".out"}, 32'(ifc.out), o);
    check({tag, ".tc"},  32'(ifc.tc),  t);
    check({tag, ".ovf"}, 32'(ifc.ovf), v);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int unsigned x, input logic clr_ovf);
    ifc.LOAD    = 1'b1;
    ifc.EN      = 1'b0;
    ifc.X       = W'(x);
    ifc.ovf_clr = clr_ovf;
    tick();
    ifc.LOAD    = 1'b0;
    ifc.ovf_clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    CLEAR         = 1'b0;
    ifc.EN        = 1'b0;
    ifc.LOAD      = 1'b1;
    ifc.X         = 16'd16;
    ifc.direction = 1'b1;
    ifc.value     = '0;
    ifc.mode      = 2'b00;
    ifc.limit     = '0;
    ifc.ovf_clr   = 1'b0;

    // 1: reset dominance, first load, asynchronous clear between edges
    tick();
    tick();
    check_all("rst", 0, 0, 0);
    CLEAR = 1'b1;
    tick();
    check("load16", 32'(ifc.out), 16);
    ifc.LOAD = 1'b0;
    #2 CLEAR = 1'b0;
    #1 check("async_clr", 32'(ifc.out), 0);
    #1 CLEAR = 1'b1;
    tick();

    // 2: wrap mode, counting down by 2 through zero
    load(16, 1'b0);
    ifc.EN = 1'b1; ifc.direction = 1'b0; ifc.value = 3'd2;
    for (int i = 7; i >= 0; i--) begin
      tick();
      check_all("wrap_dn", 32'(i * 2), 0, 0);
    end
    tick();
    check_all("wrap_borrow", 65534, 1, 1);
    tick();
    check_all("wrap_after", 65532, 0, 1);
    ifc.EN = 1'b0; ifc.ovf_clr = 1'b1;
    tick();
    ifc.ovf_clr = 1'b0;
    check_all("ovf_clr", 65532, 0, 0);

    // 3: saturate mode
    ifc.mode = 2'b01;
    load(65533, 1'b0);
    ifc.EN = 1'b1; ifc.direction = 1'b1; ifc.value = 3'd2;
    tick();
    check_all("sat_exact", 65535, 0, 0);
    tick();
    check_all("sat_clamp", 65535, 1, 1);
    load(3, 1'b1);
    check_all("sat_ld3", 3, 0, 0);
    ifc.EN = 1'b1; ifc.direction = 1'b0; ifc.value = 3'd3;
    tick();
    check_all("sat_dn_exact", 0, 0, 0);
    load(1, 1'b0);
    ifc.EN = 1'b1;
    tick();
    check_all("sat_dn_clamp", 0, 1, 1);

    // 4: modulo mode, limit 9, step 3
    ifc.mode = 2'b10; ifc.limit = 16'd9;
    load(0, 1'b1);
    check_all("mod_ld0", 0, 0, 0);
    ifc.EN = 1'b1; ifc.direction = 1'b1; ifc.value = 3'd3;
    tick(); check_all("mod_up3", 3, 0, 0);
    tick(); check_all("mod_up6", 6, 0, 0);
    tick(); check_all("mod_up9", 9, 0, 0);
    tick(); check_all("mod_upwrap", 2, 1, 1);
    ifc.direction = 1'b0;
    tick(); check_all("mod_dnwrap", 9, 1, 1);
    tick(); check_all("mod_dn6", 6, 0, 1);
    ifc.limit = 16'd5;
    load(100, 1'b0);
    check("mod_ld_clamp", 32'(ifc.out), 5);
    load(4, 1'b1);
    check_all("mod_ld4", 4, 0, 0);
    ifc.EN = 1'b1; ifc.direction = 1'b1; ifc.value = 3'd7;
    tick();
    check_all("mod_misconf", 4, 1, 1);

    // 5: priority and corner cases in wrap mode
    ifc.mode = 2'b00;
    ifc.value = 3'd1;
    ifc.LOAD = 1'b1; ifc.EN = 1'b1; ifc.X = 16'd65535; ifc.ovf_clr = 1'b1;
    tick();
    check_all("ld_over_en", 65535, 0, 0);
    ifc.LOAD = 1'b0;
    tick();
    ifc.ovf_clr = 1'b0;
    check_all("wrap_vs_clr", 0, 1, 1);
    ifc.value = 3'd0;
    tick();
    check_all("step0", 0, 0, 1);
    ifc.value = 3'd1; ifc.LOAD = 1'b1; ifc.X = 16'd100;
    tick();
    check_all("ld100_en", 100, 0, 1);
    ifc.LOAD = 1'b0; ifc.EN = 1'b0;
    tick();
    check_all("idle_hold", 100, 0, 1);

    // 6: modulo with limit lowered below the current count
    ifc.mode = 2'b10; ifc.limit = 16'd9;
    load(9, 1'b1);
    ifc.limit = 16'd5; ifc.EN = 1'b1; ifc.direction = 1'b1; ifc.value = 3'd1;
    tick();
    check_all("lim_low_up", 0, 1, 1);
    ifc.limit = 16'd9;
    load(9, 1'b1);
    ifc.limit = 16'd5; ifc.EN = 1'b1; ifc.direction = 1'b0;
    tick();
    check_all("lim_low_dn", 5, 1, 1);

    ifc.EN = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
